// File: rtl/axis_pixels_seq_pkg.sv
// Shared types for the pixel sequencer: FSM states and the packed per-image
// config header that precedes every image on the pixel stream.
package axis_pixels_seq_pkg;

  localparam int BITS_KH2           = 2;
  localparam int BITS_KW2           = 2;
  localparam int BITS_SH            = 2;
  localparam int BITS_IM_SHIFT_REGS = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_STREAM
  } state_t;

  // is_not_max lands at bit 0 of the header beat.
  typedef struct packed {
    logic [BITS_IM_SHIFT_REGS-1:0] words;
    logic [BITS_SH-1:0]            sh_1;
    logic [BITS_KW2-1:0]           kw2;
    logic [BITS_KH2-1:0]           kh2;
    logic                          is_lrelu;
    logic                          is_max;
    logic                          is_not_max;
  } cfg_t;

  localparam int CFG_WIDTH = $bits(cfg_t);

  function automatic cfg_t pack_cfg(
    input logic [2:0]                    flags,
    input logic [BITS_KH2-1:0]           kh2,
    input logic [BITS_KW2-1:0]           kw2,
    input logic [BITS_SH-1:0]            sh_1,
    input logic [BITS_IM_SHIFT_REGS-1:0] words
  );
    cfg_t c;
    c.words      = words;
    c.sh_1       = sh_1;
    c.kw2        = kw2;
    c.kh2        = kh2;
    c.is_lrelu   = flags[2];
    c.is_max     = flags[1];
    c.is_not_max = flags[0];
    return c;
  endfunction

endpackage

// File: rtl/axis_pixels_sequencer_if.sv
// AXI-stream style pixel bus used on both sides of the sequencer.
interface axis_pixels_sequencer_if #(
  parameter int W = 64
) ();
  // A beat transfers on a rising clock edge where valid && ready. Once valid
  // is raised, the master holds valid/data/keep/last stable until that edge.
  logic           valid;
  logic           ready;
  logic [W-1:0]   data;
  logic [W/8-1:0] keep;
  logic           last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axis_pixels_sequencer_reg.sv
// Enabled register primitive with asynchronous active-low clear.
module axis_pixels_sequencer_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/axis_pixels_sequencer.sv
// Per-layer sequencer: for each image emits a config header beat followed by
// the image's pixel beats. Optional stream checker: AXIS_PIXELS_SEQ_CHECK_EN.
module axis_pixels_sequencer
  import axis_pixels_seq_pkg::*;
#(
  parameter int S_PIXELS_WIDTH_LF = 64,
  parameter int BITS_BEATS        = 20,
  parameter int BITS_IMAGES       = 12
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [2:0]                    cmd_flags,
  input  logic [BITS_KH2-1:0]           cmd_kh2,
  input  logic [BITS_KW2-1:0]           cmd_kw2,
  input  logic [BITS_SH-1:0]            cmd_sh_1,
  input  logic [BITS_IM_SHIFT_REGS-1:0] cmd_words,
  input  logic [BITS_BEATS-1:0]         cmd_beats_1,
  input  logic [BITS_IMAGES-1:0]        cmd_images_1,
  axis_pixels_sequencer_if.slave        s,
  axis_pixels_sequencer_if.master       m,
  output logic                          done,
  output logic                          busy,
  output state_t                        state
`ifdef AXIS_PIXELS_SEQ_CHECK_EN
  ,
  output logic                          err,
  output logic [BITS_IMAGES-1:0]        err_img
`endif
);

  localparam int KEEP_W = S_PIXELS_WIDTH_LF / 8;

  cfg_t                   cfg;
  logic [BITS_BEATS-1:0]  beats_1;
  logic [BITS_IMAGES-1:0] images_1;

  logic [BITS_BEATS-1:0]  beat_cnt, beat_d;
  logic [BITS_IMAGES-1:0] img_cnt, img_d;
  logic                   beat_en, img_en;
  logic                   accept, m_fire, stream_fire, last_beat, final_img;

  assign accept      = (state == S_IDLE) && cmd_valid;
  assign m_fire      = m.valid && m.ready;
  assign stream_fire = (state == S_STREAM) && m_fire;
  assign last_beat   = (beat_cnt == beats_1);
  assign final_img   = (img_cnt == images_1);
  assign busy        = (state != S_IDLE);

  assign beat_en = accept || stream_fire;
  assign beat_d  = (accept || last_beat) ? '0 : beat_cnt + BITS_BEATS'(1);
  assign img_en  = accept || (stream_fire && last_beat && !final_img);
  assign img_d   = accept ? '0 : img_cnt + BITS_IMAGES'(1);

  axis_pixels_sequencer_reg #(.W(BITS_BEATS)) u_beat_cnt (
    .clk(aclk), .rst_n(aresetn), .en(beat_en), .d(beat_d), .q(beat_cnt)
  );

  axis_pixels_sequencer_reg #(.W(BITS_IMAGES)) u_img_cnt (
    .clk(aclk), .rst_n(aresetn), .en(img_en), .d(img_d), .q(img_cnt)
  );

  // Stream state is a pure passthrough so pixels see no added latency.
  always_comb begin
    cmd_ready = 1'b0;
    s.ready   = 1'b0;
    m.valid   = 1'b0;
    m.data    = '0;
    m.keep    = '0;
    m.last    = 1'b0;
    case (state)
      S_IDLE: cmd_ready = 1'b1;
      S_HEADER: begin
        m.valid = 1'b1;
        m.data  = {{(S_PIXELS_WIDTH_LF-CFG_WIDTH){1'b0}}, cfg};
        m.keep  = {KEEP_W{1'b1}};
      end
      S_STREAM: begin
        m.valid = s.valid;
        s.ready = m.ready;
        m.data  = s.data;
        m.keep  = s.keep;
        m.last  = last_beat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      cfg      <= '0;
      beats_1  <= '0;
      images_1 <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          cfg      <= pack_cfg(cmd_flags, cmd_kh2, cmd_kw2, cmd_sh_1, cmd_words);
          beats_1  <= cmd_beats_1;
          images_1 <= cmd_images_1;
          state    <= S_HEADER;
        end
        S_HEADER: if (m.ready) state <= S_STREAM;
        S_STREAM: if (m_fire && last_beat) begin
          if (final_img) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            state <= S_HEADER;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AXIS_PIXELS_SEQ_CHECK_EN
  // Counter framing is authoritative; the DMA marker is only cross-checked.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err     <= 1'b0;
      err_img <= '0;
    end else if (stream_fire && (s.last != last_beat) && !err) begin
      err     <= 1'b1;
      err_img <= img_cnt;
    end
  end
`else
  logic unused_s_last;
  assign unused_s_last = s.last;
`endif

endmodule

// File: tb/tb_axis_pixels_sequencer.sv
// Bench for axis_pixels_sequencer: header table, directed layers, random
// layers against a queue-based stream model, async reset mid-stream.
module tb_axis_pixels_sequencer;
  import axis_pixels_seq_pkg::*;

  localparam int W  = 64;
  localparam int KW = W / 8;
  localparam int BB = 20;
  localparam int BI = 12;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_flags;
  logic [1:0]    cmd_kh2, cmd_kw2, cmd_sh_1;
  logic [4:0]    cmd_words;
  logic [BB-1:0] cmd_beats_1;
  logic [BI-1:0] cmd_images_1;
  logic          done, busy;
  state_t        state;
`ifdef AXIS_PIXELS_SEQ_CHECK_EN
  logic          err;
  logic [BI-1:0] err_img;
`endif

  axis_pixels_sequencer_if #(.W(W)) s_if ();
  axis_pixels_sequencer_if #(.W(W)) m_if ();

  axis_pixels_sequencer #(
    .S_PIXELS_WIDTH_LF(W), .BITS_BEATS(BB), .BITS_IMAGES(BI)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_flags(cmd_flags),
    .cmd_kh2(cmd_kh2), .cmd_kw2(cmd_kw2), .cmd_sh_1(cmd_sh_1),
    .cmd_words(cmd_words), .cmd_beats_1(cmd_beats_1), .cmd_images_1(cmd_images_1),
    .s(s_if), .m(m_if), .done(done), .busy(busy), .state(state)
`ifdef AXIS_PIXELS_SEQ_CHECK_EN
    , .err(err), .err_img(err_img)
`endif
  );

  // ---------------- model data ----------------
  typedef struct {
    logic [2:0] flags;
    logic [1:0] kh2, kw2, sh_1;
    logic [4:0] words;
    int         beats_1;
    int         images_1;
  } cmd_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
    logic          eol;
    logic          hdr;
  } beat_t;

  typedef struct {
    logic [W-1:0]  data;
    logic [KW-1:0] keep;
    logic          last;
  } pix_t;

  typedef struct {
    logic [2:0]   flags;
    logic [1:0]   kh2, kw2, sh_1;
    logic [4:0]   words;
    logic [W-1:0] exp_hdr;
  } hdr_vec_t;

  beat_t exp_q[$];
  pix_t  pix_q[$];
  int    n_cmp = 0, n_bad = 0;
  int    m_beats = 0, px_beats = 0, done_cnt = 0;
  bit    rand_ready = 0, rand_gap = 0;
  int    seq_val = 0;
  int    flip_img = -1, flip_beat = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Header value from field weights: flags 1, kh2 8, kw2 32, sh_1 128, words 512.
  function automatic logic [W-1:0] hdr_of(input cmd_t c);
    longint v;
    v = longint'(c.flags) + 8 * longint'(c.kh2) + 32 * longint'(c.kw2)
      + 128 * longint'(c.sh_1) + 512 * longint'(c.words);
    return v;
  endfunction

  task automatic push_layer(input cmd_t c, input bit seq);
    pix_t  p;
    beat_t e;
    for (int i = 0; i <= c.images_1; i++) begin
      e.data = hdr_of(c); e.keep = '1; e.last = 1'b0; e.eol = 1'b0; e.hdr = 1'b1;
      exp_q.push_back(e);
      for (int b = 0; b <= c.beats_1; b++) begin
        p.data = seq ? W'(seq_val) : {$urandom, $urandom};
        p.keep = seq ? '1 : KW'($urandom);
        p.last = (b == c.beats_1) ^ (i == flip_img && b == flip_beat);
        seq_val++;
        pix_q.push_back(p);
        e.data = p.data; e.keep = p.keep; e.last = (b == c.beats_1);
        e.eol  = (b == c.beats_1) && (i == c.images_1); e.hdr = 1'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // ---------------- drivers ----------------
  bit s_fired;
  initial begin
    s_if.valid = 1'b0; s_if.data = '0; s_if.keep = '0; s_if.last = 1'b0;
    forever begin
      @(negedge aclk);
      s_fired = s_if.valid && s_if.ready;
      @(posedge aclk); #1;
      if (!aresetn) begin
        pix_q.delete();
        s_if.valid = 1'b0;
      end else begin
        if (s_fired && pix_q.size() > 0) void'(pix_q.pop_front());
        if (!(s_if.valid && !s_fired)) begin
          if (pix_q.size() > 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            s_if.valid = 1'b1;
            s_if.data  = pix_q[0].data;
            s_if.keep  = pix_q[0].keep;
            s_if.last  = pix_q[0].last;
          end else begin
            s_if.valid = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    m_if.ready = 1'b0;
    forever begin
      @(posedge aclk); #1;
      m_if.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_cmd(input cmd_t c);
    cmd_flags    = c.flags;
    cmd_kh2      = c.kh2;
    cmd_kw2      = c.kw2;
    cmd_sh_1     = c.sh_1;
    cmd_words    = c.words;
    cmd_beats_1  = c.beats_1[BB-1:0];
    cmd_images_1 = c.images_1[BI-1:0];
    cmd_valid    = 1'b1;
  endtask

  task automatic send_cmd(input cmd_t c);
    bit ok = 0;
    @(posedge aclk); #1;
    drive_cmd(c);
    for (int k = 0; k < 3000; k++) begin
      @(negedge aclk);
      if (cmd_ready) begin ok = 1; break; end
    end
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    if (!ok) begin n_cmp++; n_bad++; $display("FAIL cmd_accept_timeout: cmd_ready never 1"); end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge aclk);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_cmd_ready"}, cmd_ready, 1);
    chk({name, "_m_valid"}, m_if.valid, 0);
    chk({name, "_m_data"}, m_if.data, 0);
    chk({name, "_m_keep"}, m_if.keep, 0);
    chk({name, "_m_last"}, m_if.last, 0);
    chk({name, "_s_ready"}, s_if.ready, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_state"}, state, S_IDLE);
  endtask

  // ---------------- scoreboard ----------------
  bit           done_due = 0, stall_prev = 0;
  logic [W-1:0] stall_data;
  beat_t        got;
  always @(negedge aclk) begin
    if (!aresetn) begin
      exp_q.delete();
      done_due   = 0;
      stall_prev = 0;
    end else begin
      chk("done", done, done_due);
      if (done) done_cnt++;
      done_due = 0;
      if (stall_prev) begin
        chk("stall_valid", m_if.valid, 1);
        chk("stall_data", m_if.data, stall_data);
      end
      stall_prev = m_if.valid && !m_if.ready;
      stall_data = m_if.data;
      if (m_if.valid && m_if.ready) begin
        m_beats++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_beat: data %h with no beat expected", m_if.data);
        end else begin
          got = exp_q.pop_front();
          chk(got.hdr ? "hdr_data" : "px_data", m_if.data, got.data);
          chk("m_keep", m_if.keep, got.keep);
          chk("m_last", m_if.last, got.last);
          if (!got.hdr) px_beats++;
          done_due = got.eol;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  cmd_t     c, c2;
  hdr_vec_t tbl[5];
  int       mb0, dc0, pb0;
  bit       hit;

  initial begin
    tbl[0] = '{3'b010, 2'd1, 2'd1, 2'd0, 5'd10, 64'h142A};
    tbl[1] = '{3'b001, 2'd0, 2'd0, 2'd0, 5'd0,  64'h0001};
    tbl[2] = '{3'b111, 2'd3, 2'd3, 2'd3, 5'd31, 64'h3FFF};
    tbl[3] = '{3'b100, 2'd2, 2'd0, 2'd1, 5'd1,  64'h0294};
    tbl[4] = '{3'b000, 2'd0, 2'd2, 2'd2, 5'd16, 64'h2140};

    cmd_valid = 1'b0; cmd_flags = '0; cmd_kh2 = '0; cmd_kw2 = '0; cmd_sh_1 = '0;
    cmd_words = '0; cmd_beats_1 = '0; cmd_images_1 = '0;
    repeat (3) @(posedge aclk);
    #2;
    check_reset_outputs("por");
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Two images of four pixels, sink always ready
    c = '{3'b010, 2'd1, 2'd1, 2'd0, 5'd10, 3, 1};
    seq_val = 0; mb0 = m_beats; dc0 = done_cnt;
    push_layer(c, 1);
    send_cmd(c);
    wait_drain("t1");
    chk("t1_m_beats", m_beats - mb0, 10);
    chk("t1_done_cnt", done_cnt - dc0, 1);

    // Same layer with a stalling sink and gappy source
    rand_ready = 1; rand_gap = 1;
    seq_val = 0; mb0 = m_beats; dc0 = done_cnt;
    push_layer(c, 1);
    send_cmd(c);
    wait_drain("t2");
    chk("t2_m_beats", m_beats - mb0, 10);
    chk("t2_done_cnt", done_cnt - dc0, 1);

    // Single-beat single-image layer; next command held until the done cycle
    rand_ready = 0; rand_gap = 0;
    c  = '{3'b001, 2'd2, 2'd1, 2'd3, 5'd7, 0, 0};
    c2 = '{3'b100, 2'd0, 2'd3, 2'd1, 5'd3, 2, 1};
    push_layer(c, 0);
    send_cmd(c);
    push_layer(c2, 0);
    drive_cmd(c2);
    @(negedge aclk);
    chk("t3_cmd_held", cmd_ready, 0);
    hit = 0;
    for (int k = 0; k < 50; k++) begin
      if (done) begin hit = 1; break; end
      @(negedge aclk);
    end
    chk("t3_done_seen", hit, 1);
    chk("t3_ready_in_done", cmd_ready, 1);
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
    @(negedge aclk);
    chk("t3_state_after", state, S_HEADER);
    chk("t3_busy_after", busy, 1);
    wait_drain("t3");

    // Header packing table
    rand_ready = 1; rand_gap = 1;
    foreach (tbl[i]) begin
      c = '{tbl[i].flags, tbl[i].kh2, tbl[i].kw2, tbl[i].sh_1, tbl[i].words, i % 2, 0};
      push_layer(c, 0);
      send_cmd(c);
      @(negedge aclk);
      chk("tbl_hdr_valid", m_if.valid, 1);
      chk("tbl_hdr", m_if.data, tbl[i].exp_hdr);
      wait_drain("tbl");
    end

    // Async reset after two pixel beats
    rand_ready = 0; rand_gap = 0;
    c = '{3'b011, 2'd1, 2'd2, 2'd1, 5'd5, 5, 0};
    push_layer(c, 0);
    send_cmd(c);
    pb0 = px_beats; hit = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge aclk);
      if (px_beats - pb0 >= 2) begin hit = 1; break; end
    end
    chk("rst_two_beats", hit, 1);
    @(posedge aclk); #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge aclk);
    @(posedge aclk); #2;
    aresetn = 1'b1;
    dc0 = done_cnt;
    repeat (6) @(negedge aclk);
    chk("rst_no_done", done_cnt - dc0, 0);
    chk("rst_idle_ready", cmd_ready, 1);

    // Random layers
    rand_ready = 1; rand_gap = 1;
    for (int r = 0; r < 8; r++) begin
      c.flags = 3'($urandom_range(0, 7));
      c.kh2 = 2'($urandom_range(0, 3)); c.kw2 = 2'($urandom_range(0, 3));
      c.sh_1 = 2'($urandom_range(0, 3)); c.words = 5'($urandom_range(0, 31));
      c.beats_1 = $urandom_range(0, 6); c.images_1 = $urandom_range(0, 3);
      dc0 = done_cnt;
      push_layer(c, 0);
      send_cmd(c);
      wait_drain("rand");
      chk("rand_done_cnt", done_cnt - dc0, 1);
    end

`ifdef AXIS_PIXELS_SEQ_CHECK_EN
    chk("err_clean", err, 0);
    rand_ready = 0; rand_gap = 0;
    flip_img = 1; flip_beat = 2;
    c = '{3'b010, 2'd1, 2'd1, 2'd0, 5'd10, 3, 1};
    push_layer(c, 0);
    flip_img = -1; flip_beat = -1;
    send_cmd(c);
    wait_drain("err");
    chk("err_set", err, 1);
    chk("err_img", err_img, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
